// File: rtl/hs_resp_pkg.sv
// Shared definitions for handshake_responder: FSM state encoding, default
// latency bounds, latency-counter width, debug struct and the clamp helper.
package hs_resp_pkg;

    localparam int CNT_W           = 3;
    localparam int MIN_ACK_DEFAULT = 2;
    localparam int MAX_ACK_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_e;

    // Observation bundle: current FSM state and latency counter value.
    typedef struct packed {
        state_e             state;
        logic [CNT_W-1:0]   cnt;
    } hs_dbg_t;

    // Clamp a requested latency into [lo, hi].
    function automatic logic [CNT_W-1:0] clamp_lat(
        input logic [CNT_W-1:0] l,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        if (l < lo) begin
            return lo;
        end else if (l > hi) begin
            return hi;
        end else begin
            return l;
        end
    endfunction

endpackage

// File: rtl/hs_lat_counter.sv
// Latency clamp and 3-bit down-counter. On load the counter takes L-1 so that
// done (value == 1) is reached on the edge that must raise ack. It saturates
// at zero and never wraps.
module hs_lat_counter
    import hs_resp_pkg::*;
#(
    parameter int MIN_ACK_CYCLE = MIN_ACK_DEFAULT,
    parameter int MAX_ACK_CYCLE = MAX_ACK_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] lat,
    output logic [CNT_W-1:0] value,
    output logic             done
);

    localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_ACK_CYCLE);
    localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_ACK_CYCLE);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] lat_eff;

    // Next count: load clamped latency minus one, else count down to zero.
    always_comb begin
        lat_eff = clamp_lat(lat, MIN_L, MAX_L);
        cnt_d   = cnt_q;
        if (load) begin
            cnt_d = lat_eff - CNT_W'(1);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign done  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/handshake_responder.sv
// Four-phase req/ack responder. A request seen in IDLE captures req_data and
// a clamped latency L; ack pulses for one cycle L edges after capture with the
// inverted payload, then the FSM waits in RELEASE for req to drop.
// Optional macro HS_RESP_ERR_CHECK_EN: req dropping during WAIT pulses err
// and abandons the transaction; without it err is tied low.
// Handshake: req is a level held by the initiator until ack; ack is a single
// cycle pulse; ack_data is valid only while ack is high and zero otherwise.
module handshake_responder
    import hs_resp_pkg::*;
#(
    parameter int MIN_ACK_CYCLE = MIN_ACK_DEFAULT,
    parameter int MAX_ACK_CYCLE = MAX_ACK_DEFAULT,
    parameter int DATA_W        = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic [DATA_W-1:0] req_data,
    input  logic [CNT_W-1:0]  lat,
    output logic              ack,
    output logic [DATA_W-1:0] ack_data,
    output logic              busy,
    output logic              err,
    output hs_dbg_t           dbg
);

    state_e            state_q;
    logic              ack_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] ack_data_q;
    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_done;
    logic [CNT_W-1:0]  cnt_value;

    assign cnt_load = (state_q == IDLE) && req;
    assign cnt_en   = (state_q == WAIT);

    hs_lat_counter #(
        .MIN_ACK_CYCLE (MIN_ACK_CYCLE),
        .MAX_ACK_CYCLE (MAX_ACK_CYCLE)
    ) u_lat_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (cnt_load),
        .en      (cnt_en),
        .lat     (lat),
        .value   (cnt_value),
        .done    (cnt_done)
    );

`ifdef HS_RESP_ERR_CHECK_EN
    logic err_q;

    // FSM with registered ack/ack_data/err; early req drop in WAIT aborts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            ack_data_q <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            ack_q      <= 1'b0;
            ack_data_q <= '0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        data_q  <= req_data;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (cnt_done) begin
                        ack_q      <= 1'b1;
                        ack_data_q <= ~data_q;
                        state_q    <= ACK;
                    end
                end
                ACK: begin
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    if (!req) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign err = err_q;
`else
    // FSM with registered ack/ack_data; req level during WAIT is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            ack_data_q <= '0;
            data_q     <= '0;
        end else begin
            ack_q      <= 1'b0;
            ack_data_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        data_q  <= req_data;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_done) begin
                        ack_q      <= 1'b1;
                        ack_data_q <= ~data_q;
                        state_q    <= ACK;
                    end
                end
                ACK: begin
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    if (!req) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign err = 1'b0;
`endif

    assign ack       = ack_q;
    assign ack_data  = ack_data_q;
    assign busy      = (state_q != IDLE);
    assign dbg.state = state_q;
    assign dbg.cnt   = cnt_value;

endmodule

// File: doc/handshake_responder.md
HANDSHAKE_RESPONDER -- requirements
Module: handshake_responder

Interface
REQ-001 The block SHALL have parameter MIN_ACK_CYCLE, default 2, the minimum req-to-ack latency in cycles.
REQ-002 The block SHALL have parameter MAX_ACK_CYCLE, default 4, the maximum req-to-ack latency in cycles.
REQ-003 The block SHALL have parameter DATA_W, default 8, the payload width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-006 The block SHALL have port req, input, 1, the request level, held by the initiator until ack.
REQ-007 The block SHALL have port req_data, input, DATA_W, the request payload, valid with req.
REQ-008 The block SHALL have port lat, input, 3, the requested ack latency in cycles.
REQ-009 The block SHALL have port ack, output, 1, the single-cycle acknowledge pulse.
REQ-010 The block SHALL have port ack_data, output, DATA_W, the response payload, valid while ack=1.
REQ-011 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-012 The block SHALL have port err, output, 1, the single-cycle protocol-violation pulse.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, ACK and RELEASE.
REQ-014 In IDLE, req sampled high SHALL capture req_data and the effective latency L, then move to WAIT.
REQ-015 L SHALL be lat clamped to [MIN_ACK_CYCLE, MAX_ACK_CYCLE]: below MIN gives MIN; above MAX gives MAX.
REQ-016 If the edge that first samples req high is edge T, ack SHALL be 1 in exactly the cycle after edge T+L-1, then 0.
REQ-017 ack_data SHALL equal the captured req_data with bitwise inversion, registered, valid only while ack=1 and 0 otherwise.
REQ-018 After ACK the FSM SHALL enter RELEASE and stay there until req is sampled low, then move to IDLE.
REQ-019 A new request SHALL be accepted no earlier than the first IDLE edge sampling req high; back-to-back minimum spacing is one low cycle of req.
REQ-020 Changes on lat and req_data outside the IDLE-capture edge SHALL have no effect on the current transaction.
REQ-021 The latency counter SHALL be 3 bits wide, SHALL count down, and SHALL never wrap.

Reset
REQ-022 On reset_n low, the FSM SHALL go to IDLE asynchronously, and ack, ack_data, busy, err and the counter SHALL go to 0.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction with no ack; the first post-reset IDLE edge with req high SHALL start a new one.

Configuration
REQ-024 Macro HS_RESP_ERR_CHECK_EN SHALL control early-drop checking.
REQ-025 With HS_RESP_ERR_CHECK_EN defined, req sampled low in WAIT SHALL pulse err for one cycle, suppress ack and return to IDLE.
REQ-026 Without HS_RESP_ERR_CHECK_EN, req in WAIT SHALL be ignored, the transaction SHALL complete with ack, and err SHALL be tied 0.

Structure
REQ-027 A shared package hs_resp_pkg SHALL hold the FSM state encoding, the default MIN/MAX latency constants and the counter width.
REQ-028 The latency clamp and down-counter SHALL be one sub-module, hs_lat_counter, with load, value and done outputs; the FSM and datapath stay in the top.

Verification
REQ-029 The bench SHALL cover: lat=3, req high at edge 10 with req_data=8'hA5 -> ack=1 only in the cycle after edge 12, ack_data=8'h5A, busy high from edge 10 until RELEASE exits.
REQ-030 The bench SHALL cover: lat=0 and then lat=7 -> ack latencies of 2 and 4 cycles respectively.
REQ-031 The bench SHALL cover: req held high 3 cycles after ack, then dropped -> no second ack, IDLE one edge after req is sampled low, next req accepted.
REQ-032 The bench SHALL cover: with HS_RESP_ERR_CHECK_EN, req dropped 1 cycle into WAIT -> one err pulse, no ack, busy=0 next cycle; without the macro -> ack after L and err=0.
REQ-033 The bench SHALL cover: reset_n pulsed low during WAIT -> all outputs 0 immediately, no ack, and a clean transaction afterwards.
REQ-034 The bench SHALL bind an ovl_handshake checker with min 2 and max 4 to req/ack and SHALL see zero fire bits across all scenarios without err.
